// File: rtl/motor_act_stream_pkg.sv
// Shared activation-mode encodings and default sample format for the motor activation stream.
package motor_act_stream_pkg;

  typedef enum logic [1:0] {
    MODE_RELU   = 2'd0,
    MODE_LEAKY  = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_BYPASS = 2'd3
  } act_mode_e;

  localparam int unsigned DEF_W = 32;
  localparam int unsigned DEF_F = 24;

endpackage

// File: rtl/motor_act_lane.sv
// Single-channel signed activation (ReLU / leaky / clipped ReLU / bypass) with a clip-event flag.
module motor_act_lane
  import motor_act_stream_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LS = 3
) (
  input  logic signed [W-1:0] x,
  input  act_mode_e           mode,
  input  logic signed [W-1:0] clip,
  output logic        [W-1:0] y,
  output logic                clip_evt
);

  logic x_pos;
  logic clip_pos;

  always_comb begin
    x_pos    = !x[W-1] && (x != '0);
    clip_pos = !clip[W-1] && (clip != '0);
    y        = '0;
    clip_evt = 1'b0;
    unique case (mode)
      MODE_RELU:   y = x_pos ? x : '0;
      MODE_LEAKY:  y = x[W-1] ? (x >>> LS) : x;
      MODE_CLIP: begin
        // A non-positive ceiling forces zero and never reports a clip.
        if (clip_pos && x_pos) begin
          if (x > clip) begin
            y        = clip;
            clip_evt = 1'b1;
          end else begin
            y = x;
          end
        end
      end
      MODE_BYPASS: y = x;
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/motor_act_stream.sv
// Two-stage valid/ready activation pipeline over N packed channels with a saturating clip counter.
module motor_act_stream
  import motor_act_stream_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned F  = DEF_F,
  parameter int unsigned N  = 4,
  parameter int unsigned LS = 3,
  parameter int unsigned CW = 16
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [1:0]     in_mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   cfg_clip,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  clip_cnt,
  input  logic           cnt_clr
);

  // F only describes the sample format; no datapath depends on it.
  if (F >= W) begin : g_frac_wider_than_sample
  end

  logic           v1_q, v1_d;
  logic           v2_q, v2_d;
  logic [N*W-1:0] d1_q, d1_d;
  act_mode_e      mode1_q, mode1_d;
  logic [W-1:0]   clip1_q, clip1_d;
  logic [N*W-1:0] out_q, out_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           adv1;
  logic           adv2;
  logic [N*W-1:0] lane_y;
  logic [N-1:0]   lane_evt;
  int unsigned    ev_n;
  logic [CW:0]    cnt_sum;

  for (genvar k = 0; k < N; k++) begin : g_lane
    motor_act_lane #(
      .W  (W),
      .LS (LS)
    ) u_lane (
      .x        (d1_q[k*W +: W]),
      .mode     (mode1_q),
      .clip     (clip1_q),
      .y        (lane_y[k*W +: W]),
      .clip_evt (lane_evt[k])
    );
  end

  always_comb begin
    adv2     = !v2_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = ap_rst_n && adv1;

    v1_d    = v1_q;
    d1_d    = d1_q;
    mode1_d = mode1_q;
    clip1_d = clip1_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        d1_d    = in_data;
        mode1_d = act_mode_e'(in_mode);
        clip1_d = cfg_clip;
      end
    end

    v2_d  = v2_q;
    out_d = out_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) out_d = lane_y;
    end
  end

  // Clip events are counted only on the S1-to-S2 transfer, so a stalled beat counts once.
  always_comb begin
    ev_n = 0;
    if (v1_q && adv2) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (lane_evt[k]) ev_n = ev_n + 1;
      end
    end
    cnt_sum = {1'b0, cnt_q} + (CW+1)'(ev_n);
    if (cnt_clr)           cnt_d = '0;
    else if (cnt_sum[CW])  cnt_d = '1;
    else                   cnt_d = cnt_sum[CW-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d1_q    <= '0;
      mode1_q <= MODE_RELU;
      clip1_q <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      d1_q    <= d1_d;
      mode1_q <= mode1_d;
      clip1_q <= clip1_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = v2_q;
  assign clip_cnt  = cnt_q;

endmodule

// File: doc/motor_act_stream.md
MOTOR_ACT_STREAM -- requirements
Module: motor_act_stream

Interface
REQ-001 SHALL have parameter W, default 32: bit width of each channel sample (signed fixed point).
REQ-002 SHALL have parameter F, default 24: fractional bits; used only for documentation and test scaling, with no arithmetic dependence.
REQ-003 SHALL have parameter N, default 4: number of channels per beat.
REQ-004 SHALL have parameter LS, default 3: leaky slope as an arithmetic right-shift amount (slope = 2^-LS).
REQ-005 SHALL have parameter CW, default 16: width of the clip-event counter.
REQ-006 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port ap_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port in_data, input, N*W bits: channel k occupies bits [k*W+W-1 : k*W].
REQ-009 SHALL have port in_mode, input, 2 bits: activation mode, sampled with the beat.
REQ-010 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-012 SHALL have port cfg_clip, input, W bits: signed clip ceiling for mode 2, sampled with the beat.
REQ-013 SHALL have port out_data, output, N*W bits: activated channels, using the same packing as in_data.
REQ-014 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-016 SHALL have port clip_cnt, output, CW bits: saturating count of clipped channel samples.
REQ-017 SHALL have port cnt_clr, input, 1 bit: synchronous clear of clip_cnt.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready, and SHALL deliver a beat when out_valid && out_ready.
REQ-019 SHALL be a 2-stage pipeline (S1 capture, S2 output register) with exactly 2 cycles of latency from acceptance to out_valid when no stall occurs.
REQ-020 SHALL compute adv2 = !v2 || out_ready and in_ready = !v1 || adv2; it SHALL sustain one beat per cycle under continuous out_ready.
REQ-021 S1 SHALL hold its data, mode and clip value and S2 SHALL hold out_data stable while out_valid && !out_ready; no beat is dropped or duplicated.
REQ-022 Mode 0 (ReLU): y = x when x > 0, else 0.
REQ-023 Mode 1 (leaky): y = x when x >= 0, else x >>> LS (arithmetic shift, floor rounding).
REQ-024 Mode 2 (clipped ReLU): y = min(max(x, 0), cfg_clip); if cfg_clip <= 0, then y = 0 for all channels.
REQ-025 Mode 3 (bypass): y = x.
REQ-026 All comparisons SHALL be signed W-bit, and outputs SHALL be exactly W bits with no overflow possible.
REQ-027 In mode 2, each channel with x > cfg_clip and cfg_clip > 0 SHALL count as one clip event at S1-to-S2 transfer; up to N events are added per beat.
REQ-028 clip_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-029 cnt_clr SHALL have priority: a clear in the same cycle as events yields 0, and those events are discarded.
REQ-030 Channels SHALL be fully independent; the mode applies to all N channels of a beat.

Reset
REQ-031 While ap_rst_n = 0 at a clock edge, v1, v2 and clip_cnt SHALL become 0, out_valid = 0 and out_data = 0.
REQ-032 in_ready SHALL be 0 during reset and 1 in the first cycle after reset.
REQ-033 Reset mid-stream SHALL discard all in-flight beats with no partial output.

Structure
REQ-034 A shared package SHALL hold the mode encodings (MODE_RELU=0, MODE_LEAKY=1, MODE_CLIP=2, MODE_BYPASS=3) and default W/F constants.
REQ-035 The design SHALL contain one sub-module, motor_act_lane: a combinational single-channel activation plus clip flag, instantiated N times by generate.

Verification (W=32, F=24, N=4, LS=3; 1.0 = 0x01000000)
REQ-036 Mode 0 with in = {0xFF000000, 0, 1, 0x7FFFFFFF}, out_ready=1 -> two cycles later out = {0, 0, 1, 0x7FFFFFFF}.
REQ-037 Mode 1 with x = 0xF8000000 (-8.0) -> 0xFF000000 (-1.0); x = 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-038 Mode 2 with cfg_clip = 0x06000000 and in = {0x07000000, 0x05000000, 0xFF000000, 0x06000000} -> out = {0x06000000, 0x05000000, 0, 0x06000000}, clip_cnt += 1; with cfg_clip = 0xFF000000 -> all 0.
REQ-039 100 back-to-back beats with out_ready toggling randomly -> output sequence equals the model in order, out_data stable during stalls, and full throughput while out_ready=1.
REQ-040 Set CW=4 and drive 5 beats each with 4 clip events -> clip_cnt = 15 and holds; cnt_clr asserted alongside an event beat -> 0.
REQ-041 Drive ap_rst_n=0 for one cycle with 2 beats in flight -> out_valid=0 next cycle, clip_cnt=0, and no stale beat emerges afterwards.
